// File: rtl/peripheral_cmd_pkg.sv
// Shared constants, state encoding and response payload for the peripheral command master.
package peripheral_cmd_pkg;

  localparam int unsigned CMD_LEN = 6;
  localparam int unsigned IDX_W   = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_LEN - 1);

  localparam logic [7:0] OP_RD = 8'h01;
  localparam logic [7:0] OP_WR = 8'h02;

  localparam logic [7:0] ST_RD_OK      = 8'h00;
  localparam logic [7:0] ST_WR_OK      = 8'h01;
  localparam logic [7:0] ST_BAD_OPCODE = 8'hE0;
  localparam logic [7:0] ST_MALFORMED  = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT    = 8'hE2;
  localparam logic [7:0] ST_MISALIGNED = 8'hE3;

  typedef enum logic [2:0] {
    COLLECT,
    DRAIN,
    ISSUE,
    WAIT_RDV,
    RESP
  } state_t;

  typedef struct packed {
    logic [7:0]  status;
    logic [7:0]  addr;
    logic [31:0] data;
  } rsp_word_t;

  // Byte idx of the response frame, data sent big-endian.
  function automatic logic [7:0] rsp_byte(input rsp_word_t w, input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    rsp_byte = w.status;
      3'd1:    rsp_byte = w.addr;
      3'd2:    rsp_byte = w.data[31:24];
      3'd3:    rsp_byte = w.data[23:16];
      3'd4:    rsp_byte = w.data[15:8];
      default: rsp_byte = w.data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/peripheral_cmd_rsp_ser.sv
// Serialises one status/address/data word into a 6-byte sop/eop framed stream.
module peripheral_cmd_rsp_ser
  import peripheral_cmd_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  rsp_word_t word,
  input  logic      rsp_ready,
  output logic [7:0] rsp_data,
  output logic      rsp_valid,
  output logic      rsp_sop,
  output logic      rsp_eop,
  output logic      done_c
);

  rsp_word_t        word_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      idx_q     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_sop   <= 1'b0;
      rsp_eop   <= 1'b0;
    end else if (load) begin
      word_q    <= word;
      idx_q     <= '0;
      rsp_data  <= word.status;
      rsp_valid <= 1'b1;
      rsp_sop   <= 1'b1;
      rsp_eop   <= 1'b0;
    end else if (rsp_valid && rsp_ready) begin
      if (idx_q == LAST_IDX) begin
        rsp_data  <= '0;
        rsp_valid <= 1'b0;
        rsp_sop   <= 1'b0;
        rsp_eop   <= 1'b0;
      end else begin
        idx_q    <= idx_q + IDX_W'(1);
        rsp_data <= rsp_byte(word_q, idx_q + IDX_W'(1));
        rsp_sop  <= 1'b0;
        rsp_eop  <= ((idx_q + IDX_W'(1)) == LAST_IDX);
      end
    end
  end

  assign done_c = rsp_valid && rsp_ready && (idx_q == LAST_IDX);

endmodule

// File: rtl/peripheral_cmd_master.sv
// Byte-stream command decoder issuing single-beat Avalon-MM reads/writes with framed responses.
module peripheral_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TMO_W          = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  input  logic        cmd_sop,
  input  logic        cmd_eop,
  output logic        cmd_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  output logic        rsp_sop,
  output logic        rsp_eop,
  input  logic        rsp_ready,
  output logic [7:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  output logic        avm_burstcount,
  output logic        avm_debugaccess,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);
  import peripheral_cmd_pkg::*;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             in_frame_q, in_frame_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rd_d, wr_d;
  logic             load_c;
  rsp_word_t        rsp_word_c;
  logic             rsp_done_c;
  logic             cmd_xfer_c;
  logic             timeout_c;

  assign cmd_xfer_c = cmd_valid && cmd_ready;
  assign timeout_c  = (tmo_q >= TMO_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= COLLECT;
      cnt_q          <= '0;
      in_frame_q     <= 1'b0;
      op_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      tmo_q          <= '0;
      cmd_ready      <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'h0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      in_frame_q     <= in_frame_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      tmo_q          <= tmo_d;
      cmd_ready      <= (state_d == COLLECT) || (state_d == DRAIN);
      avm_read       <= rd_d;
      avm_write      <= wr_d;
      avm_byteenable <= (rd_d || wr_d) ? 4'hF : 4'h0;
    end
  end

  // Next-state, frame capture, request control and response launch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_frame_d = in_frame_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tmo_d      = tmo_q;
    rd_d       = avm_read;
    wr_d       = avm_write;
    load_c     = 1'b0;
    rsp_word_c = '0;

    case (state_q)
      COLLECT: begin
        if (cmd_xfer_c) begin
          if (cmd_sop) begin
            op_d       = cmd_data;
            addr_d     = '0;
            wdata_d    = '0;
            cnt_d      = IDX_W'(1);
            in_frame_d = !cmd_eop;
            if (cmd_eop) begin
              cnt_d             = '0;
              load_c            = 1'b1;
              rsp_word_c.status = ST_MALFORMED;
              state_d           = RESP;
            end
          end else if (in_frame_q) begin
            if (cnt_q == IDX_W'(1)) addr_d = cmd_data;
            else                    wdata_d = {wdata_q[23:0], cmd_data};
            if (cnt_q == LAST_IDX) begin
              cnt_d      = '0;
              in_frame_d = 1'b0;
              if (!cmd_eop) begin
                state_d = DRAIN;
              end else if (op_q != OP_RD && op_q != OP_WR) begin
                load_c            = 1'b1;
                rsp_word_c.status = ST_BAD_OPCODE;
                state_d           = RESP;
              end else if (addr_q[1:0] != 2'b00) begin
                load_c            = 1'b1;
                rsp_word_c.status = ST_MISALIGNED;
                state_d           = RESP;
              end else begin
                tmo_d   = '0;
                rd_d    = (op_q == OP_RD);
                wr_d    = (op_q == OP_WR);
                state_d = ISSUE;
              end
            end else if (cmd_eop) begin
              cnt_d             = '0;
              in_frame_d        = 1'b0;
              load_c            = 1'b1;
              rsp_word_c.status = ST_MALFORMED;
              state_d           = RESP;
            end else begin
              cnt_d = cnt_q + IDX_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (cmd_xfer_c && cmd_eop) begin
          load_c            = 1'b1;
          rsp_word_c.status = ST_MALFORMED;
          state_d           = RESP;
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!avm_waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (avm_write) begin
            load_c            = 1'b1;
            rsp_word_c.status = ST_WR_OK;
            state_d           = RESP;
          end else begin
            state_d = WAIT_RDV;
          end
        end else if (timeout_c) begin
          rd_d              = 1'b0;
          wr_d              = 1'b0;
          load_c            = 1'b1;
          rsp_word_c.status = ST_TIMEOUT;
          state_d           = RESP;
        end
      end
      WAIT_RDV: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (avm_readdatavalid) begin
          load_c            = 1'b1;
          rsp_word_c.status = ST_RD_OK;
          rsp_word_c.data   = avm_readdata;
          state_d           = RESP;
        end else if (timeout_c) begin
          load_c            = 1'b1;
          rsp_word_c.status = ST_TIMEOUT;
          state_d           = RESP;
        end
      end
      RESP: begin
        if (rsp_done_c) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase

    rsp_word_c.addr = addr_d;
  end

  assign avm_address     = addr_q;
  assign avm_writedata   = wdata_q;
  assign avm_burstcount  = 1'b1;
  assign avm_debugaccess = 1'b0;

  peripheral_cmd_rsp_ser u_rsp_ser (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .load      (load_c),
    .word      (rsp_word_c),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_sop   (rsp_sop),
    .rsp_eop   (rsp_eop),
    .done_c    (rsp_done_c)
  );

endmodule

// File: tb/tb_peripheral_cmd_master.sv
// Directed bench for peripheral_cmd_master with hand-computed response frames.
module tb_peripheral_cmd_master;

  logic        clk_clk;
  logic        reset_reset_n;
  logic [7:0]  cmd_data;
  logic        cmd_valid, cmd_sop, cmd_eop, cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid, rsp_sop, rsp_eop, rsp_ready;
  logic [7:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_burstcount, avm_debugaccess, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int errors = 0;
  int checks = 0;
  bit rand_ready = 1'b0;
  int req_cycles = 0;
  int rsp_frames = 0;

  peripheral_cmd_master #(.TIMEOUT_CYCLES(16), .TMO_W(16)) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .cmd_data          (cmd_data),
    .cmd_valid         (cmd_valid),
    .cmd_sop           (cmd_sop),
    .cmd_eop           (cmd_eop),
    .cmd_ready         (cmd_ready),
    .rsp_data          (rsp_data),
    .rsp_valid         (rsp_valid),
    .rsp_sop           (rsp_sop),
    .rsp_eop           (rsp_eop),
    .rsp_ready         (rsp_ready),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_burstcount    (avm_burstcount),
    .avm_debugaccess   (avm_debugaccess),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  always @(posedge clk_clk) begin
    if (avm_read || avm_write) req_cycles <= req_cycles + 1;
    if (rsp_valid && rsp_ready && rsp_sop) rsp_frames <= rsp_frames + 1;
  end

  // Sends n bytes taken MSB-first from the low n bytes of b.
  task automatic send_frame(input logic [63:0] b, input int n, input bit with_sop, input bit with_eop);
    int wait_n;
    for (int i = 0; i < n; i++) begin
      cmd_data  = b[8*(n-1-i) +: 8];
      cmd_valid = 1'b1;
      cmd_sop   = with_sop && (i == 0);
      cmd_eop   = with_eop && (i == n - 1);
      wait_n    = 0;
      while (cmd_ready !== 1'b1 && wait_n < 50) begin
        @(posedge clk_clk); #1;
        wait_n++;
      end
      checks++;
      if (wait_n >= 50) begin
        errors++;
        $display("FAIL cmd_accept byte %0d: cmd_ready=%b, required 1 within 50 cycles", i, cmd_ready);
      end
      @(posedge clk_clk); #1;
    end
    cmd_valid = 1'b0;
    cmd_sop   = 1'b0;
    cmd_eop   = 1'b0;
    cmd_data  = 8'h00;
  endtask

  // Collects one six-byte response frame and checks framing and cmd_ready handshake.
  task automatic get_rsp(output logic [47:0] frm);
    int idx, n;
    bit flag_bad, rdy_bad;
    idx = 0; n = 0; flag_bad = 0; rdy_bad = 0;
    frm = '0;
    while (idx < 6 && n < 400) begin
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid === 1'b1) begin
        if (cmd_ready !== 1'b0) rdy_bad = 1;
        if (rsp_ready) begin
          if (rsp_sop !== (idx == 0) || rsp_eop !== (idx == 5)) flag_bad = 1;
          frm = {frm[39:0], rsp_data};
          idx++;
        end
      end
      @(posedge clk_clk); #1;
      n++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (idx != 6) begin
      errors++;
      $display("FAIL rsp_bytes: got %0d bytes, required 6", idx);
    end
    checks++;
    if (flag_bad) begin
      errors++;
      $display("FAIL rsp_framing: sop/eop wrong, required sop on R0 and eop on R5 only");
    end
    checks++;
    if (rdy_bad || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_handoff: cmd_ready_during_rsp=%0d cmd_ready_after=%b rsp_valid_after=%b, required 0/1/0",
               rdy_bad, cmd_ready, rsp_valid);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int nwait);
    int n;
    bit stable_bad;
    logic [47:0] f;
    avm_waitrequest = (nwait > 0);
    send_frame({16'h0, 8'h02, a, d}, 6, 1, 1);
    n = 0; stable_bad = 0;
    while (avm_write === 1'b1 && n < 40) begin
      if (avm_address !== a || avm_writedata !== d || avm_byteenable !== 4'hF || avm_read !== 1'b0)
        stable_bad = 1;
      n++;
      if (n > nwait) avm_waitrequest = 1'b0;
      @(posedge clk_clk); #1;
    end
    avm_waitrequest = 1'b0;
    checks++;
    if (n != nwait + 1) begin
      errors++;
      $display("FAIL write_hold: avm_write high %0d cycles, required %0d", n, nwait + 1);
    end
    checks++;
    if (stable_bad) begin
      errors++;
      $display("FAIL write_bus: addr/data/be not held, required addr=%h data=%h be=f", a, d);
    end
    get_rsp(f);
    checks++;
    if (f !== {8'h01, a, 32'h0}) begin
      errors++;
      $display("FAIL write_rsp: got %h, required %h", f, {8'h01, a, 32'h0});
    end
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] d);
    logic [47:0] f;
    avm_waitrequest = 1'b0;
    send_frame({16'h0, 8'h01, a, 32'h0}, 6, 1, 1);
    checks++;
    if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_address !== a || avm_byteenable !== 4'hF) begin
      errors++;
      $display("FAIL read_req: rd=%b wr=%b addr=%h be=%h, required 1 0 %h f",
               avm_read, avm_write, avm_address, avm_byteenable, a);
    end
    avm_readdatavalid = 1'b1;
    avm_readdata      = ~d;
    @(posedge clk_clk); #1;
    avm_readdatavalid = 1'b0;
    checks++;
    if (avm_read !== 1'b0 || avm_byteenable !== 4'h0) begin
      errors++;
      $display("FAIL read_drop: rd=%b be=%h, required 0 0", avm_read, avm_byteenable);
    end
    @(posedge clk_clk); #1;
    avm_readdatavalid = 1'b1;
    avm_readdata      = d;
    @(posedge clk_clk); #1;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    get_rsp(f);
    checks++;
    if (f !== {8'h00, a, d}) begin
      errors++;
      $display("FAIL read_rsp: got %h, required %h", f, {8'h00, a, d});
    end
  endtask

  task automatic test_reset();
    reset_reset_n     = 1'b0;
    cmd_data          = 8'h00;
    cmd_valid         = 1'b0;
    cmd_sop           = 1'b0;
    cmd_eop           = 1'b0;
    rsp_ready         = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = 32'h0;
    avm_readdatavalid = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_sop, rsp_eop, avm_read, avm_write, avm_debugaccess} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {cmd_ready, rsp_valid, rsp_sop, rsp_eop, avm_read, avm_write, avm_debugaccess});
    end
    checks++;
    if (rsp_data !== 8'h0 || avm_address !== 8'h0 || avm_writedata !== 32'h0 || avm_byteenable !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: rsp=%h addr=%h wd=%h be=%h, required all 0",
               rsp_data, avm_address, avm_writedata, avm_byteenable);
    end
    checks++;
    if (avm_burstcount !== 1'b1) begin
      errors++;
      $display("FAIL reset_burst: got %b, required 1", avm_burstcount);
    end
    reset_reset_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_release: got %b, required 0", cmd_ready);
    end
    @(posedge clk_clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_errors();
    logic [47:0] f;
    int r0, f0;
    r0 = req_cycles;
    send_frame(64'h05_10_01_02_03_04, 6, 1, 1);
    get_rsp(f);
    checks++;
    if (f !== 48'hE0_10_00000000) begin
      errors++;
      $display("FAIL bad_opcode: got %h, required e01000000000", f);
    end
    send_frame(64'h01_13_00_00_00_00, 6, 1, 1);
    get_rsp(f);
    checks++;
    if (f !== 48'hE3_13_00000000) begin
      errors++;
      $display("FAIL misaligned: got %h, required e31300000000", f);
    end
    send_frame(64'h01_24_00_00, 4, 1, 1);
    get_rsp(f);
    checks++;
    if (f !== 48'hE1_24_00000000) begin
      errors++;
      $display("FAIL short_frame: got %h, required e12400000000", f);
    end
    f0 = rsp_frames;
    send_frame(64'h02_10_11_22_33_44_55_66, 8, 1, 1);
    get_rsp(f);
    checks++;
    if (f !== 48'hE1_10_00000000) begin
      errors++;
      $display("FAIL long_frame: got %h, required e11000000000", f);
    end
    repeat (10) @(posedge clk_clk);
    #1;
    checks++;
    if (rsp_frames - f0 != 1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL long_frame_once: frames=%0d rsp_valid=%b, required 1 0", rsp_frames - f0, rsp_valid);
    end
    checks++;
    if (req_cycles != r0) begin
      errors++;
      $display("FAIL err_no_request: request cycles=%0d, required 0", req_cycles - r0);
    end
  endtask

  task automatic test_timeout();
    logic [47:0] f;
    int n;
    avm_waitrequest = 1'b1;
    send_frame(64'h01_20_00_00_00_00, 6, 1, 1);
    n = 0;
    while (avm_read === 1'b1 && n < 40) begin
      @(posedge clk_clk); #1;
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_len: avm_read high %0d cycles, required 16", n);
    end
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'hFFFF_FFFF;
    @(posedge clk_clk); #1;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    get_rsp(f);
    checks++;
    if (f !== 48'hE2_20_00000000) begin
      errors++;
      $display("FAIL timeout_rsp: got %h, required e22000000000", f);
    end
    do_read(8'h04, 32'hA5A5_5A5A);
  endtask

  task automatic test_sop_inject();
    logic [47:0] f;
    int f0;
    rand_ready = 1'b1;
    f0 = rsp_frames;
    avm_waitrequest = 1'b0;
    send_frame(64'h02_08_AA, 3, 1, 0);
    send_frame(64'h02_08_CA_FE_BA_BE, 6, 1, 1);
    checks++;
    if (avm_write !== 1'b1 || avm_writedata !== 32'hCAFE_BABE || avm_address !== 8'h08) begin
      errors++;
      $display("FAIL restart_write: wr=%b data=%h addr=%h, required 1 cafebabe 08",
               avm_write, avm_writedata, avm_address);
    end
    get_rsp(f);
    checks++;
    if (f !== 48'h01_08_00000000) begin
      errors++;
      $display("FAIL restart_rsp: got %h, required 010800000000", f);
    end
    repeat (10) @(posedge clk_clk);
    #1;
    checks++;
    if (rsp_frames - f0 != 1) begin
      errors++;
      $display("FAIL truncated_silent: frames=%0d, required 1", rsp_frames - f0);
    end
    send_frame(64'h99, 1, 0, 0);
    do_read(8'h30, 32'h0BAD_F00D);
    do_write(8'h3C, 32'h1357_9BDF, 2);
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    rsp_ready = 1'b0;
    send_frame(64'h07_00_00_00_00_00, 6, 1, 1);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: rsp_valid=%b, required 1", rsp_valid);
    end
    #2;
    reset_reset_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sop !== 1'b0 || cmd_ready !== 1'b0 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_reset: valid=%b sop=%b ready=%b data=%h, required 0 0 0 00",
               rsp_valid, rsp_sop, cmd_ready, rsp_data);
    end
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: ready=%b valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    do_write(8'h0C, 32'h0102_0304, 0);
  endtask

  initial begin
    test_reset();
    do_write(8'h10, 32'hDEAD_BEEF, 3);
    do_read(8'h24, 32'h1234_5678);
    test_errors();
    test_timeout();
    test_sop_inject();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
